// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack handshake that carries a held payload into another clock domain.
// Optional ack-timeout detection is built when CDC_HS_TX_TIMEOUT_EN is defined.
module cdc_handshake_tx #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx_req,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_ack_async,
  output logic             tx_done,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic             ack_meta_reg;
  logic             ack_sync_reg;
  logic             tx_req_reg;
  logic [WIDTH-1:0] tx_data_reg;
  logic             tx_done_reg;
  logic             load_word;
  logic             done_next;

  // The only place the far-domain ack is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta_reg <= 1'b0;
      ack_sync_reg <= 1'b0;
    end else begin
      ack_meta_reg <= tx_ack_async;
      ack_sync_reg <= ack_meta_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)      state_next = REQ;
      REQ:     if (ack_sync_reg)  state_next = RELEASE;
      RELEASE: if (!ack_sync_reg) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE) && !rst;
    load_word = (state_reg == IDLE) && in_valid;
    done_next = (state_reg == RELEASE) && !ack_sync_reg;
  end

  // Handshake outputs come straight from flops so the far side never sees glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_req_reg  <= 1'b0;
      tx_data_reg <= '0;
      tx_done_reg <= 1'b0;
    end else begin
      tx_req_reg  <= (state_next == REQ);
      tx_done_reg <= done_next;
      if (load_word) begin
        tx_data_reg <= in_data;
      end
    end
  end

  assign tx_req  = tx_req_reg;
  assign tx_data = tx_data_reg;
  assign tx_done = tx_done_reg;

`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] timer_reg;
  logic          timeout_reg;
  logic          waiting;
  logic          entering;

  assign waiting  = (state_reg == REQ) || (state_reg == RELEASE);
  assign entering = (state_next != state_reg) &&
                    ((state_next == REQ) || (state_next == RELEASE));

  // Counter saturates at its limit; the flag is raised in the same edge the count gets there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (entering) begin
        timer_reg <= '0;
      end else if (waiting && (timer_reg != TW'(TIMEOUT_CYCLES - 1))) begin
        timer_reg <= timer_reg + TW'(1);
      end
      if (waiting && !entering && ((timer_reg + TW'(1)) == TW'(TIMEOUT_CYCLES - 1))) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench: the driver queues each offered word, a far-side model pops and checks it.
// Timeout expectations follow CDC_HS_TX_TIMEOUT_EN.
module tb_cdc_handshake_tx;
  localparam int WIDTH = 32;
  localparam int TOUT  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             tx_req;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ack_async = 1'b0;
  logic             tx_done;
  logic             timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int exp_done = 0;
  bit ack_en = 1'b1;
  logic [WIDTH-1:0] exp_q[$];

`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  cdc_handshake_tx #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .tx_req(tx_req), .tx_data(tx_data), .tx_ack_async(tx_ack_async), .tx_done(tx_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Far-side model: ack 3 cycles after req rises, drop 3 cycles after req falls.
  bit               req_seen = 1'b0;
  bit               done_prev = 1'b0;
  int               ack_cnt = 0;
  int               since_ack = 0;
  logic [WIDTH-1:0] held;
  always @(negedge clk) begin
    if (rst) begin
      tx_ack_async = 1'b0;
      req_seen = 1'b0;
      done_prev = 1'b0;
      ack_cnt = 0;
      since_ack = 0;
    end else begin
      if (tx_req && !req_seen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", 64'(tx_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          held = exp_q.pop_front();
          check("rx_word", 64'(tx_data), 64'(held));
          $display("[TB] far side received %h", tx_data);
        end
        held = tx_data;
      end else if (tx_req && req_seen) begin
        check("tx_data_hold", 64'(tx_data), 64'(held));
      end
      if (!tx_req && req_seen) check("req_fall_lat", 64'(since_ack), 64'd2);
      if (tx_done) begin
        done_cnt++;
        $display("[TB] tx_done pulse %0d", done_cnt);
        check("done_lat", 64'(since_ack), 64'd2);
        check("ready_at_done", 64'(in_ready), 64'd1);
        check("done_width", 64'(done_prev), 64'd0);
      end
      done_prev = tx_done;
      req_seen = tx_req;
      since_ack++;
      if (ack_en) begin
        if (tx_req && !tx_ack_async) begin
          ack_cnt++;
          if (ack_cnt == 3) begin tx_ack_async = 1'b1; ack_cnt = 0; since_ack = 0; end
        end else if (!tx_req && tx_ack_async) begin
          ack_cnt++;
          if (ack_cnt == 3) begin tx_ack_async = 1'b0; ack_cnt = 0; since_ack = 0; end
        end
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following the accept edge.
  task automatic send(input logic [WIDTH-1:0] w);
    int n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      in_data = ~w;
      @(negedge clk);
      n++;
    end
    check("ready_wait", 64'(in_ready), 64'd1);
    in_data = w;
    exp_q.push_back(w);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt != exp_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_count", 64'(done_cnt), 64'(exp_done));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_tx_req", 64'(tx_req), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_tx_done", 64'(tx_done), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(in_ready), 64'd1);

    // Single word
    send(32'hDEAD_BEEF);
    exp_done++;
    in_valid = 1'b0;
    check("first_req", 64'(tx_req), 64'd1);
    check("first_data", 64'(tx_data), 64'hDEAD_BEEF);
    check("first_ready", 64'(in_ready), 64'd0);
    wait_done();

    // Stream with in_valid held high and in_data scrambled while busy
    for (int i = 1; i <= 3; i++) begin
      send(WIDTH'(i));
      exp_done++;
    end
    in_valid = 1'b0;
    wait_done();
    check("data_idle_hold", 64'(tx_data), 64'h3);

    // Reset in the middle of REQ: word is lost, no tx_done
    ack_en = 1'b0;
    send(32'h5555_AAAA);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_req", 64'(tx_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_tx_req", 64'(tx_req), 64'd0);
    check("abort_tx_data", 64'(tx_data), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    check("abort_done_cnt", 64'(done_cnt), 64'(exp_done));
    send(32'h7777_0001);
    exp_done++;
    in_valid = 1'b0;
    wait_done();

    // Ack withheld: timeout flag behaviour, req held throughout
    ack_en = 1'b0;
    send(32'hA5A5_5A5A);
    in_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      check($sformatf("timeout_k%0d", k), 64'(timeout_err), 64'(TO_ON && (k >= TOUT - 1)));
      check("req_held", 64'(tx_req), 64'd1);
      @(negedge clk);
    end
    ack_en = 1'b1;
    exp_done++;
    wait_done();
    check("timeout_sticky", 64'(timeout_err), 64'(TO_ON));

    repeat (4) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_done_cnt", 64'(done_cnt), 64'(exp_done));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cdc_handshake_tx.md
CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, ack-wait limit in clk cycles (used only with CDC_HS_TX_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  source offers in_data.
REQ-006 SHALL have port in_data  input  WIDTH  payload from source.
REQ-007 SHALL have port in_ready  output  1  block can accept a word.
REQ-008 SHALL have port tx_req  output  1  4-phase request to far domain, driven from a flop.
REQ-009 SHALL have port tx_data  output  WIDTH  held payload, driven from a flop.
REQ-010 SHALL have port tx_ack_async  input  1  acknowledge from far domain, asynchronous to clk.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse on handshake completion.
REQ-012 SHALL have port timeout_err  output  1  sticky ack-timeout flag.

Function
REQ-013 SHALL synchronise tx_ack_async through exactly two flops (ack_sync = second stage); no other logic SHALL sample tx_ack_async.
REQ-014 SHALL implement states IDLE, REQ, RELEASE.
REQ-015 in_ready SHALL be 1 exactly when state is IDLE and rst is low; combinational from state.
REQ-016 IDLE: on in_valid=1, SHALL capture in_data into tx_data, set tx_req=1, go to REQ (tx_req visible one cycle after accept edge).
REQ-017 IDLE with in_valid=0: SHALL hold; tx_data SHALL keep last value.
REQ-018 REQ: tx_req and tx_data SHALL stay constant; when ack_sync=1 SHALL clear tx_req and go to RELEASE.
REQ-019 RELEASE: when ack_sync=0 SHALL go to IDLE and pulse tx_done for exactly that one following cycle.
REQ-020 in_data changes while not IDLE SHALL NOT affect tx_data.
REQ-021 ack_sync=1 while in IDLE (spurious/stale ack) SHALL be ignored; a new word SHALL still be accepted, and REQ SHALL then wait for ack to fall and rise again only in the sense that it exits on ack_sync=1 (far side guarantees return-to-zero before next ack).
REQ-022 Minimum word period SHALL be 1 (accept) + 2 (ack rise sync) + 2 (ack fall sync) cycles plus far-side latency; back-to-back in_valid SHALL be accepted in the cycle after tx_done.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, tx_req=0, tx_data=0, tx_done=0, timeout_err=0, both sync flops=0, timeout counter=0.
REQ-024 in_ready SHALL be 0 while rst=1 and 1 on the first edge after release.
REQ-025 rst asserted mid-handshake SHALL abort the transfer with no tx_done; the word is lost.

Configuration
REQ-026 Macro CDC_HS_TX_TIMEOUT_EN defined: a counter SHALL clear on entry to REQ or RELEASE, increment each cycle in those states, and on reaching TIMEOUT_CYCLES-1 set timeout_err=1 (sticky until rst); state machine SHALL continue waiting, unaffected.
REQ-027 Macro undefined: no counter SHALL be built and timeout_err SHALL be constant 0.

Verification
REQ-028 Reset released, in_valid=1, in_data=0xDEADBEEF one cycle -> next cycle tx_req=1, tx_data=0xDEADBEEF, in_ready=0.
REQ-029 Far-side model raises ack 3 cycles after req, drops it 3 cycles after req falls -> tx_req falls 2 cycles after ack rise, tx_done single pulse 2 cycles after ack fall, in_ready=1 same cycle as tx_done.
REQ-030 Stream 0x1,0x2,0x3 with in_valid held high and in_data changed mid-handshake -> far side receives exactly 0x1,0x2,0x3 in order, three tx_done pulses.
REQ-031 rst pulsed while in REQ -> tx_req=0, tx_data=0 without waiting for clk edge, no tx_done, next word accepted normally.
REQ-032 With CDC_HS_TX_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never asserted -> timeout_err=1 on 16th cycle in REQ, tx_req stays 1; later ack completes handshake, timeout_err stays 1.
REQ-033 Without macro, same stimulus -> timeout_err=0 throughout.
